lc3_dmem_arbiter: RTL and testbench

- Sequences and shares the single-port data memory between two requesters:
  - the MemAccess stage (MA port, carrying the MControl/MAddr/MData/DMem_out/completedata traffic);
  - a secondary DMA/loader port used for memory preload and dump.
- Performs two-phase LDI/STI indirect sequencing: a pointer read, then the final read or write.
- Handles memories with variable wait states (mem_rdy), with a timeout.
- Sits between the MemAccess stage and the data SRAM model.

---
 rtl/lc3_dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_lc3_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_dmem_arbiter.sv
// LC-3 data-memory arbiter: shares one single-port SRAM between the MemAccess
// stage (with LDI/STI pointer indirection) and a DMA/loader port.
module lc3_dmem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int MA_PRIORITY  = 1,
  parameter int DMA_MAX_WAIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ma_req,
  input  logic          ma_we,
  input  logic          ma_indirect,
  input  logic [AW-1:0] ma_addr,
  input  logic [DW-1:0] ma_wdata,
  output logic [DW-1:0] ma_rdata,
  output logic          ma_done,
  output logic          ma_err,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_done,
  output logic          dma_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy
);
  localparam int WCW = $clog2(DMA_MAX_WAIT + 2);
  localparam int TCW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, PH1, PH2, FIN} state_t;

  state_t         state;
  logic           sel_dma;
  logic           we_q;
  logic           ind_q;
  logic           rr_last_dma;
  logic           pick_dma;
  logic [WCW-1:0] wait_cnt;
  logic [TCW-1:0] tcnt;
  logic [TCW-1:0] tcnt_inc;
  logic           timed_out;
  logic           finish;
  logic           stall;

  assign tcnt_inc  = tcnt + 1'b1;
  assign timed_out = (tcnt_inc == TCW'(TIMEOUT));

  // A phase is live while mem_en is up; the PH2 entry cycle has mem_en low.
  assign finish = mem_rdy && ((state == PH1 && !ind_q) || (state == PH2 && mem_en));
  assign stall  = !mem_rdy && (state == PH1 || (state == PH2 && mem_en));

  always_comb begin
    pick_dma = 1'b0;
    if (dma_req && !ma_req) begin
      pick_dma = 1'b1;
    end else if (dma_req && ma_req) begin
      if (MA_PRIORITY != 0) pick_dma = (wait_cnt == WCW'(DMA_MAX_WAIT));
      else                  pick_dma = !rr_last_dma;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      sel_dma     <= 1'b0;
      we_q        <= 1'b0;
      ind_q       <= 1'b0;
      rr_last_dma <= 1'b0;
      wait_cnt    <= '0;
      tcnt        <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ma_rdata    <= '0;
      dma_rdata   <= '0;
      ma_done     <= 1'b0;
      ma_err      <= 1'b0;
      dma_done    <= 1'b0;
      dma_err     <= 1'b0;
    end else begin
      ma_done  <= 1'b0;
      ma_err   <= 1'b0;
      dma_done <= 1'b0;
      dma_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (ma_req || dma_req) begin
            sel_dma     <= pick_dma;
            rr_last_dma <= pick_dma;
            ind_q       <= !pick_dma && ma_indirect;
            we_q        <= pick_dma ? dma_we : ma_we;
            mem_en      <= 1'b1;
            mem_we      <= pick_dma ? dma_we : (ma_we && !ma_indirect);
            mem_addr    <= pick_dma ? dma_addr : ma_addr;
            mem_wdata   <= pick_dma ? dma_wdata : ma_wdata;
            tcnt        <= '0;
            if (MA_PRIORITY != 0) begin
              if (pick_dma)     wait_cnt <= '0;
              else if (dma_req) wait_cnt <= wait_cnt + 1'b1;
            end
            state <= PH1;
          end
        end
        PH1: begin
          // Pointer fetched: drop the strobe for one cycle, then re-issue at the pointer.
          if (mem_rdy && ind_q) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= AW'(mem_rdata);
            state    <= PH2;
          end
        end
        PH2: begin
          if (!mem_en) begin
            mem_en <= 1'b1;
            mem_we <= we_q;
            tcnt   <= '0;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if (finish) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        state  <= FIN;
        if (sel_dma) begin
          dma_done <= 1'b1;
          if (!we_q) dma_rdata <= mem_rdata;
        end else begin
          ma_done <= 1'b1;
          if (!we_q) ma_rdata <= mem_rdata;
        end
      end

      if (stall) begin
        if (timed_out) begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          tcnt   <= '0;
          state  <= FIN;
          if (sel_dma) dma_err <= 1'b1;
          else         ma_err  <= 1'b1;
        end else begin
          tcnt <= tcnt_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_lc3_dmem_arbiter.sv
// Self-checking bench for lc3_dmem_arbiter: vector table, phase/timing sequences,
// contention order for both arbitration modes, timeout and mid-access reset.
module tb_lc3_dmem_arbiter;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        ma_req, ma_we, ma_indirect, dma_req, dma_we;
  logic [15:0] ma_addr, ma_wdata, dma_addr, dma_wdata;
  logic [15:0] ma_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        ma_done, ma_err, dma_done, dma_err, mem_en, mem_we, mem_rdy;

  lc3_dmem_arbiter #(.AW(16), .DW(16), .MA_PRIORITY(1), .DMA_MAX_WAIT(4), .TIMEOUT(15)) u_dut (
    .clock(clock), .reset(reset),
    .ma_req(ma_req), .ma_we(ma_we), .ma_indirect(ma_indirect), .ma_addr(ma_addr),
    .ma_wdata(ma_wdata), .ma_rdata(ma_rdata), .ma_done(ma_done), .ma_err(ma_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done), .dma_err(dma_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  // Round-robin instance with a trivial always-ready memory.
  logic        m2_req, m2_we, m2_ind, d2_req, d2_we;
  logic [15:0] m2_addr, m2_wd, d2_addr, d2_wd;
  logic [15:0] m2_rdata, d2_rdata, mem2_addr, mem2_wdata, mem2_rdata;
  logic        m2_done, m2_err, d2_done, d2_err, mem2_en, mem2_we, mem2_rdy;

  lc3_dmem_arbiter #(.AW(16), .DW(16), .MA_PRIORITY(0), .DMA_MAX_WAIT(4), .TIMEOUT(15)) u_rr (
    .clock(clock), .reset(reset),
    .ma_req(m2_req), .ma_we(m2_we), .ma_indirect(m2_ind), .ma_addr(m2_addr),
    .ma_wdata(m2_wd), .ma_rdata(m2_rdata), .ma_done(m2_done), .ma_err(m2_err),
    .dma_req(d2_req), .dma_we(d2_we), .dma_addr(d2_addr), .dma_wdata(d2_wd),
    .dma_rdata(d2_rdata), .dma_done(d2_done), .dma_err(d2_err),
    .mem_en(mem2_en), .mem_we(mem2_we), .mem_addr(mem2_addr), .mem_wdata(mem2_wdata),
    .mem_rdata(mem2_rdata), .mem_rdy(mem2_rdy)
  );

  assign mem2_rdata = mem2_addr ^ 16'h5A5A;
  assign mem2_rdy   = mem2_en;

  // SRAM model with programmable wait states and a backdoor preload.
  logic [15:0] mem [0:65535];
  int          wait_n;
  bit          rdy_never;
  int          wcnt;
  logic        pl_we;
  logic [15:0] pl_addr, pl_data;

  assign mem_rdy   = mem_en && !rdy_never && (wcnt >= wait_n);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    wcnt <= (mem_en && !mem_rdy) ? wcnt + 1 : 0;
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_en && mem_we && mem_rdy) mem[mem_addr] <= mem_wdata;
  end

  typedef struct { bit err; logic [15:0] rd; } exp_t;
  typedef struct { bit we; bit ind; logic [15:0] addr; logic [15:0] wd; logic [15:0] rd; int lat; } vec_t;

  exp_t ma_q[$];
  exp_t dma_q[$];
  int   total, bad;
  logic        log_en  [0:127];
  logic        log_we  [0:127];
  logic        log_rdy [0:127];
  logic [15:0] log_addr[0:127];
  logic [15:0] log_wd  [0:127];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clock);
    pl_we = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {mem_en, mem_we, ma_done, ma_err, dma_done, dma_err}, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwd"}, mem_wdata, 0);
    chk({tag, "_ma_rd"}, ma_rdata, 0);
    chk({tag, "_dma_rd"}, dma_rdata, 0);
  endtask

  // Expected response is queued at issue and popped when the port responds.
  task automatic txn(input string tag, input bit dma, input bit we, input bit ind,
                     input logic [15:0] addr, input logic [15:0] wd,
                     input bit exp_err, input logic [15:0] exp_rd, output int lat);
    exp_t e;
    bit   got;
    int   k;
    @(negedge clock);
    e.err = exp_err;
    e.rd  = exp_rd;
    ma_indirect = ind;
    if (dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
      dma_q.push_back(e);
    end else begin
      ma_req = 1'b1; ma_we = we; ma_addr = addr; ma_wdata = wd;
      ma_q.push_back(e);
    end
    got = 1'b0;
    k   = 0;
    while (!got && k < 100) begin
      @(negedge clock);
      k++;
      log_en[k] = mem_en; log_we[k] = mem_we; log_rdy[k] = mem_rdy;
      log_addr[k] = mem_addr; log_wd[k] = mem_wdata;
      got = dma ? (dma_done || dma_err) : (ma_done || ma_err);
    end
    lat = k;
    chk({tag, "_resp"}, got, 1);
    if (got) begin
      if (dma) begin
        e = dma_q.pop_front();
        chk({tag, "_err"}, dma_err, e.err);
        chk({tag, "_done"}, dma_done, !e.err);
        if (!e.err) chk({tag, "_rdata"}, dma_rdata, e.rd);
      end else begin
        e = ma_q.pop_front();
        chk({tag, "_err"}, ma_err, e.err);
        chk({tag, "_done"}, ma_done, !e.err);
        if (!e.err) chk({tag, "_rdata"}, ma_rdata, e.rd);
      end
    end
    ma_req = 1'b0; dma_req = 1'b0; ma_indirect = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    int   lat, cnt, rdy_k, stable;
    bit   seen;
    int   order[$];

    total = 0; bad = 0;
    reset = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    wait_n = 0; rdy_never = 1'b0;
    ma_req = 0; ma_we = 0; ma_indirect = 0; ma_addr = '0; ma_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    m2_req = 0; m2_we = 0; m2_ind = 0; m2_addr = 16'h1000; m2_wd = '0;
    d2_req = 0; d2_we = 0; d2_addr = 16'h2000; d2_wd = '0;

    vt[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'hBEEF, 2};
    vt[1] = '{1'b1, 1'b0, 16'h3100, 16'hA5A5, 16'hBEEF, 2};
    vt[2] = '{1'b0, 1'b0, 16'h3100, 16'h0000, 16'hA5A5, 2};
    vt[3] = '{1'b0, 1'b1, 16'h3020, 16'h0000, 16'hBEEF, 4};
    vt[4] = '{1'b1, 1'b1, 16'h3010, 16'h1234, 16'hBEEF, 4};
    vt[5] = '{1'b0, 1'b0, 16'h4000, 16'h0000, 16'h1234, 2};
    vt[6] = '{1'b0, 1'b1, 16'h3010, 16'h0000, 16'h1234, 4};

    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b1;

    preload(16'h3000, 16'hBEEF);
    preload(16'h3010, 16'h4000);
    preload(16'h3020, 16'h3000);
    preload(16'h3030, 16'h4100);
    preload(16'h3040, 16'h3000);

    for (int i = 0; i < 7; i++) begin
      txn($sformatf("vec%0d", i), 1'b0, vt[i].we, vt[i].ind, vt[i].addr, vt[i].wd, 1'b0, vt[i].rd, lat);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
    end

    // STI: pointer read, one idle cycle, write at the pointer.
    txn("sti", 1'b0, 1'b1, 1'b1, 16'h3030, 16'h5678, 1'b0, 16'h1234, lat);
    chk("sti_lat", lat, 4);
    chk("sti_ph1", {log_en[1], log_we[1], log_addr[1]}, {1'b1, 1'b0, 16'h3030});
    chk("sti_gap", log_en[2], 0);
    chk("sti_ph2", {log_en[3], log_we[3], log_addr[3]}, {1'b1, 1'b1, 16'h4100});
    chk("sti_ph2_wd", log_wd[3], 16'h5678);
    chk("sti_mem", mem[16'h4100], 16'h5678);

    // DMA write with three wait states.
    wait_n = 3;
    txn("dmaw", 1'b1, 1'b1, 1'b0, 16'h5000, 16'hCAFE, 1'b0, 16'h0000, lat);
    wait_n = 0;
    stable = 0; rdy_k = -1;
    for (int k = 1; k <= lat; k++) begin
      if (log_en[k] && log_we[k] && log_addr[k] == 16'h5000 && log_wd[k] == 16'hCAFE) stable++;
      if (log_en[k] && log_rdy[k] && rdy_k < 0) rdy_k = k;
    end
    chk("dmaw_stable", stable, 4);
    chk("dmaw_done_after_rdy", lat, rdy_k + 1);
    chk("dmaw_mem", mem[16'h5000], 16'hCAFE);

    // DMA never does indirection even with ma_indirect high.
    txn("dmar", 1'b1, 1'b0, 1'b1, 16'h5000, 16'h0000, 1'b0, 16'hCAFE, lat);
    chk("dmar_lat", lat, 2);

    // Timeout: no mem_rdy at all.
    rdy_never = 1'b1;
    txn("tmo", 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1, 16'h0000, lat);
    rdy_never = 1'b0;
    cnt = 0;
    for (int k = 1; k <= lat; k++) if (log_en[k]) cnt++;
    chk("tmo_en_cycles", cnt, 15);
    chk("tmo_err_lat", lat, 16);
    chk("tmo_rdata_hold", ma_rdata, 16'h1234);
    txn("tmo_next", 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0, 16'hBEEF, lat);
    chk("tmo_next_lat", lat, 2);

    // Fixed-priority contention with starvation guard.
    @(negedge clock); reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    ma_req = 1; ma_we = 0; ma_addr = 16'h3000;
    dma_req = 1; dma_we = 0; dma_addr = 16'h5000;
    order.delete();
    for (int k = 0; k < 200 && order.size() < 10; k++) begin
      @(negedge clock);
      if (ma_done) order.push_back(0);
      if (dma_done) order.push_back(1);
    end
    ma_req = 0; dma_req = 0;
    chk("prio_grants", order.size(), 10);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("prio_order%0d", i), order[i], (i % 5 == 4) ? 1 : 0);
    chk("prio_ma_rd", ma_rdata, 16'hBEEF);
    chk("prio_dma_rd", dma_rdata, 16'hCAFE);

    // Round-robin contention must alternate.
    @(negedge clock);
    m2_req = 1; d2_req = 1;
    order.delete();
    for (int k = 0; k < 200 && order.size() < 10; k++) begin
      @(negedge clock);
      if (m2_done) order.push_back(0);
      if (d2_done) order.push_back(1);
    end
    m2_req = 0; d2_req = 0;
    chk("rr_grants", order.size(), 10);
    for (int i = 1; i < order.size(); i++)
      chk($sformatf("rr_alt%0d", i), order[i] != order[i-1], 1);
    chk("rr_ma_rd", m2_rdata, 16'h4A5A);
    chk("rr_dma_rd", d2_rdata, 16'h7A5A);

    // Reset during PH2 of an LDI.
    @(negedge clock);
    ma_req = 1; ma_we = 0; ma_indirect = 1; ma_addr = 16'h3040;
    repeat (3) @(negedge clock);
    chk("rst_in_ph2", {mem_en, mem_addr}, {1'b1, 16'h3000});
    reset = 1'b0; ma_req = 0; ma_indirect = 0;
    @(negedge clock);
    check_zero("midrst");
    reset = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (ma_done || ma_err || mem_en) seen = 1'b1;
    end
    chk("midrst_quiet", seen, 0);
    txn("post_rst", 1'b0, 1'b0, 1'b0, 16'h3100, 16'h0000, 1'b0, 16'hA5A5, lat);
    chk("post_rst_lat", lat, 2);

    chk("ma_q_empty", ma_q.size(), 0);
    chk("dma_q_empty", dma_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
